// File: rtl/wiegand_pkg.sv
// Shared Wiegand definitions for the transmitter and input decoder.
// Frame size, FSM states, channel codes, timing defaults, parity.
package wiegand_pkg;

  localparam int WG_BITS = 26;

  localparam int WG_PULSE_W    = 100;
  localparam int WG_BIT_PERIOD = 2000;
  localparam int WG_FRAME_GAP  = 6000;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SPACE,
    FGAP
  } wg_state_e;

  typedef enum logic [1:0] {
    CH_OUT0 = 2'b00,
    CH_OUT1 = 2'b01,
    CH_OUT2 = 2'b10,
    CH_ALL  = 2'b11
  } wg_chan_e;

  function automatic int wg_max(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Bit that makes the total count of ones even.
  function automatic logic wg_even_par(logic [11:0] v);
    return ^v;
  endfunction

  // Bit that makes the total count of ones odd.
  function automatic logic wg_odd_par(logic [11:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/wiegand_tx_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
// Loading N gives exactly N cycles until the state ends.
module wiegand_timer
  import wiegand_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start_i,
  input  logic [W-1:0] len_i,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  // Reload on a state change, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= len_i - ONE;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/wiegand_tx.sv
// 26-bit Wiegand transmitter: shifts a latched word MSB first onto
// up to three D0/D1 line pairs and raises an active-low done interrupt.
module wiegand_tx
  import wiegand_pkg::*;
#(
  parameter int PULSE_W    = WG_PULSE_W,
  parameter int BIT_PERIOD = WG_BIT_PERIOD,
  parameter int FRAME_GAP  = WG_FRAME_GAP,
  parameter int GEN_PARITY = 1
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        load,
  input  logic [25:0] data_in,
  input  logic [1:0]  chan_sel,
  input  logic        ack,
  output logic        busy,
  output logic        eint_wil_output,
  output logic [1:0]  wil_out0,
  output logic [1:0]  wil_out1,
  output logic [1:0]  wil_out2
);

  localparam int CW =
    $clog2(wg_max(BIT_PERIOD, FRAME_GAP)) + 1;

  localparam logic [CW-1:0] LEN_PULSE = CW'(PULSE_W);
  localparam logic [CW-1:0] LEN_SPACE = CW'(BIT_PERIOD - PULSE_W);
  localparam logic [CW-1:0] LEN_GAP   = CW'(FRAME_GAP);
  localparam logic [4:0]    LAST_BIT  = 5'(WG_BITS - 1);

  wg_state_e            state_q, state_d;
  logic [WG_BITS-1:0]   sreg_q, sreg_d;
  logic [1:0]           chan_q, chan_d;
  logic [4:0]           bcnt_q, bcnt_d;
  logic                 busy_q, busy_d;
  logic                 eint_q, eint_d;
  logic [1:0]           out0_q, out0_d;
  logic [1:0]           out1_q, out1_d;
  logic [1:0]           out2_q, out2_d;
  logic [WG_BITS-1:0]   load_word;
  logic [1:0]           pair;
  logic                 tstart;
  logic [CW-1:0]        tlen;
  logic                 tc;

  wiegand_timer #(
    .W(CW)
  ) u_timer (
    .clk    (clk),
    .nReset (nReset),
    .start_i(tstart),
    .len_i  (tlen),
    .tc_o   (tc)
  );

  // Frame word as latched: optionally overwrite the parity positions.
  always_comb begin
    load_word = data_in;
    if (GEN_PARITY != 0) begin
      load_word[25] = wg_even_par(data_in[24:13]);
      load_word[0]  = wg_odd_par(data_in[12:1]);
    end
  end

  // Next state, timer control and the registered line levels.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    chan_d  = chan_q;
    bcnt_d  = bcnt_q;
    busy_d  = busy_q;
    eint_d  = eint_q;
    tstart  = 1'b0;
    tlen    = LEN_PULSE;
    if (ack) eint_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sreg_d  = load_word;
          chan_d  = chan_sel;
          bcnt_d  = '0;
          busy_d  = 1'b1;
          eint_d  = 1'b1;
          state_d = PULSE;
          tstart  = 1'b1;
          tlen    = LEN_PULSE;
        end
      end
      PULSE: begin
        if (tc) begin
          state_d = SPACE;
          tstart  = 1'b1;
          tlen    = LEN_SPACE;
        end
      end
      SPACE: begin
        if (tc) begin
          sreg_d = {sreg_q[WG_BITS-2:0], 1'b0};
          bcnt_d = bcnt_q + 5'd1;
          tstart = 1'b1;
          if (bcnt_q == LAST_BIT) begin
            state_d = FGAP;
            tlen    = LEN_GAP;
          end else begin
            state_d = PULSE;
            tlen    = LEN_PULSE;
          end
        end
      end
      FGAP: begin
        if (tc) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          eint_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    pair = 2'b11;
    if (state_d == PULSE) begin
      pair = sreg_d[WG_BITS-1] ? 2'b01 : 2'b10;
    end
    out0_d = 2'b11;
    out1_d = 2'b11;
    out2_d = 2'b11;
    if (chan_d == CH_OUT0 || chan_d == CH_ALL) out0_d = pair;
    if (chan_d == CH_OUT1 || chan_d == CH_ALL) out1_d = pair;
    if (chan_d == CH_OUT2 || chan_d == CH_ALL) out2_d = pair;
  end

  // State and output registers; reset releases all lines at once.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      chan_q  <= '0;
      bcnt_q  <= '0;
      busy_q  <= 1'b0;
      eint_q  <= 1'b1;
      out0_q  <= 2'b11;
      out1_q  <= 2'b11;
      out2_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      chan_q  <= chan_d;
      bcnt_q  <= bcnt_d;
      busy_q  <= busy_d;
      eint_q  <= eint_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign busy            = busy_q;
  assign eint_wil_output = eint_q;
  assign wil_out0        = out0_q;
  assign wil_out1        = out1_q;
  assign wil_out2        = out2_q;

endmodule
